// File: rtl/moorefsm_pkg.sv
// -----------------------------------------------------------------------------
// moorefsm_pkg
// Shared constants for the 1010 serial pattern detector.
//   STATE_W     : width of the state register (3).
//   S0..S4      : state encodings (idle, "1", "10", "101", "1010" detect).
//   Q_W         : width of the detect output bus (3).
//   Q_DETECT    : q value in the detect state (3'b001).
//   Q_IDLE      : q value in every other state (3'b000).
//   decode_q()  : maps a state code to the Moore output value.
// Configuration macro: MOOREFSM_OVERLAP_EN (consumed in moorefsm_nsl).
// -----------------------------------------------------------------------------
package moorefsm_pkg;

  localparam int STATE_W = 3;
  localparam int Q_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    S0 = 3'd0,  // idle
    S1 = 3'd1,  // seen "1"
    S2 = 3'd2,  // seen "10"
    S3 = 3'd3,  // seen "101"
    S4 = 3'd4   // seen "1010", detect
  } state_t;

  localparam logic [Q_W-1:0] Q_DETECT = 3'b001;
  localparam logic [Q_W-1:0] Q_IDLE   = 3'b000;

  // Moore output decode. Illegal codes 5..7 fall through to Q_IDLE.
  function automatic logic [Q_W-1:0] decode_q(input logic [STATE_W-1:0] st);
    logic [Q_W-1:0] q_val;
    q_val = Q_IDLE;
    if (st == S4) begin
      q_val = Q_DETECT;
    end
    return q_val;
  endfunction

endpackage

// File: rtl/moorefsm_nsl.sv
// -----------------------------------------------------------------------------
// moorefsm_nsl
// Purely combinational next-state logic for the 1010 detector.
//   pst : input,  3 bits - present state code
//   i   : input,  1 bit  - serial data bit
//   nst : output, 3 bits - next state code
// Configuration macro: MOOREFSM_OVERLAP_EN
//   defined   : from S4 a '1' goes to S3 (the trailing "10" is reused).
//   undefined : from S4 a '1' goes to S1 (only that '1' is reused).
// Illegal codes 5..7 always recover to S0.
// -----------------------------------------------------------------------------
module moorefsm_nsl
  import moorefsm_pkg::*;
(
  input  logic [STATE_W-1:0] pst,
  input  logic               i,
  output logic [STATE_W-1:0] nst
);

  logic [STATE_W-1:0] nst_next;

  always_comb begin
    nst_next = S0;
    case (pst)
      S0: nst_next = i ? S1 : S0;
      S1: nst_next = i ? S1 : S2;
      S2: nst_next = i ? S3 : S0;
      S3: nst_next = i ? S1 : S4;
`ifdef MOOREFSM_OVERLAP_EN
      S4: nst_next = i ? S3 : S0;
`else
      S4: nst_next = i ? S1 : S0;
`endif
      default: nst_next = S0;
    endcase
  end

  assign nst = nst_next;

endmodule

// File: rtl/moorefsm.sv
// -----------------------------------------------------------------------------
// moorefsm
// Moore-style detector for the serial pattern 1010 (first bit first) on i.
//   clk : input,  1 bit  - sole clock, rising edge
//   rst : input,  1 bit  - asynchronous, active-low reset
//   i   : input,  1 bit  - serial data bit
//   q   : output, 3 bits - q[0] = pattern found, q[2:1] reserved (0)
//   pst : output, 3 bits - present state register
//   nst : output, 3 bits - combinational next state
// Configuration macro: MOOREFSM_OVERLAP_EN (overlapping detection, see
// moorefsm_nsl).
// q is decoded from the registered state only, so it never glitches with i.
// -----------------------------------------------------------------------------
module moorefsm
  import moorefsm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i,
  output logic [Q_W-1:0]     q,
  output logic [STATE_W-1:0] pst,
  output logic [STATE_W-1:0] nst
);

  logic [STATE_W-1:0] pst_reg;
  logic [STATE_W-1:0] nst_next;
  logic [Q_W-1:0]     q_dec;

  moorefsm_nsl u_nsl (
    .pst (pst_reg),
    .i   (i),
    .nst (nst_next)
  );

  // State register. While rst is low the register is held at S0, so nst
  // keeps showing the transition out of S0 for the current i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pst_reg <= S0;
    end else begin
      pst_reg <= nst_next;
    end
  end

  assign q_dec = decode_q(pst_reg);

  // Drive each q bit from the decode; reserved bits come out as 0 from it.
  for (genvar gi = 0; gi < Q_W; gi++) begin : g_q
    assign q[gi] = q_dec[gi];
  end

  assign pst = pst_reg;
  assign nst = nst_next;

endmodule

// File: tb/tb_moorefsm.sv
// -----------------------------------------------------------------------------
// tb_moorefsm
// Directed bench for moorefsm. Inputs change on the falling clock edge;
// outputs are sampled 1 time unit after the rising edge. A standalone
// moorefsm_nsl instance exercises the illegal state codes 5..7.
// -----------------------------------------------------------------------------
module tb_moorefsm;
  import moorefsm_pkg::*;

  logic       clk;
  logic       rst;
  logic       i;
  logic [2:0] q;
  logic [2:0] pst;
  logic [2:0] nst;

  logic [2:0] ill_pst;
  logic       ill_i;
  logic [2:0] ill_nst;

  int compared;
  int mismatched;

  moorefsm dut (
    .clk (clk),
    .rst (rst),
    .i   (i),
    .q   (q),
    .pst (pst),
    .nst (nst)
  );

  moorefsm_nsl u_nsl_chk (
    .pst (ill_pst),
    .i   (ill_i),
    .nst (ill_nst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one bit at the falling edge, clock it in, then check pst and q.
  task automatic step(input string tag, input logic bit_in,
                      input logic [2:0] exp_pst, input logic [2:0] exp_q);
    @(negedge clk);
    i = bit_in;
    @(posedge clk);
    #1;
    check({tag, "_pst"}, pst, exp_pst);
    check({tag, "_q"}, q, exp_q);
    $display("step %s i=%0d pst=%0d q=%03b", tag, bit_in, pst, q);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    ill_pst    = 3'd0;
    ill_i      = 1'b0;
    i          = 1'b0;
    rst        = 1'b0;

    // Reset held low with i toggling for 3 edges.
    #1;
    check("rst_init_pst", pst, 3'd0);
    check("rst_init_q", q, 3'b000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i = (k % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      check("rst_nst", nst, (k % 2 == 0) ? 3'd1 : 3'd0);
      @(posedge clk);
      #1;
      check("rst_pst", pst, 3'd0);
      check("rst_q", q, 3'b000);
      $display("reset edge %0d i=%0d pst=%0d nst=%0d q=%03b", k, i, pst, nst, q);
    end

    // Release reset away from the clock edge.
    @(negedge clk);
    rst = 1'b1;
    i   = 1'b0;

    // Basic detect 1,0,1,0.
    step("basic1", 1'b1, 3'd1, 3'b000);
    step("basic2", 1'b0, 3'd2, 3'b000);
    step("basic3", 1'b1, 3'd3, 3'b000);
    step("basic4", 1'b0, 3'd4, 3'b001);
    step("basic_idle", 1'b0, 3'd0, 3'b000);

    // 1,0,1,0,1,0 overlap behaviour.
    step("ovl1", 1'b1, 3'd1, 3'b000);
    step("ovl2", 1'b0, 3'd2, 3'b000);
    step("ovl3", 1'b1, 3'd3, 3'b000);
    step("ovl4", 1'b0, 3'd4, 3'b001);
`ifdef MOOREFSM_OVERLAP_EN
    step("ovl5", 1'b1, 3'd3, 3'b000);
    step("ovl6", 1'b0, 3'd4, 3'b001);
`else
    step("ovl5", 1'b1, 3'd1, 3'b000);
    step("ovl6", 1'b0, 3'd2, 3'b000);
`endif
    step("ovl_idle", 1'b0, 3'd0, 3'b000);

    // Near misses 1,1,0,0,1,0,1,1,0.
    step("nm1", 1'b1, 3'd1, 3'b000);
    step("nm2", 1'b1, 3'd1, 3'b000);
    step("nm3", 1'b0, 3'd2, 3'b000);
    step("nm4", 1'b0, 3'd0, 3'b000);
    step("nm5", 1'b1, 3'd1, 3'b000);
    step("nm6", 1'b0, 3'd2, 3'b000);
    step("nm7", 1'b1, 3'd3, 3'b000);
    step("nm8", 1'b1, 3'd1, 3'b000);
    step("nm9", 1'b0, 3'd2, 3'b000);
    step("nm_idle", 1'b0, 3'd0, 3'b000);

    // Async reset mid-pattern after 1,0,1.
    step("ar1", 1'b1, 3'd1, 3'b000);
    step("ar2", 1'b0, 3'd2, 3'b000);
    step("ar3", 1'b1, 3'd3, 3'b000);
    @(negedge clk);
    i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("ar_async_pst", pst, 3'd0);
    check("ar_async_q", q, 3'b000);
    check("ar_async_nst", nst, 3'd0);
    $display("async reset mid-pattern pst=%0d q=%03b nst=%0d", pst, q, nst);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ar_after_pst", pst, 3'd0);
    check("ar_after_q", q, 3'b000);
    $display("after reset i=0 pst=%0d q=%03b", pst, q);
    step("ar_resume", 1'b1, 3'd1, 3'b000);

    // Illegal codes 5..7 on the next-state logic and the output decode.
    for (int s = 5; s < 8; s++) begin
      for (int b = 0; b < 2; b++) begin
        ill_pst = 3'(s);
        ill_i   = b[0];
        #1;
        check("illegal_nst", ill_nst, 3'd0);
        check("illegal_q", decode_q(ill_pst), 3'b000);
        $display("illegal pst=%0d i=%0d nst=%0d q=%03b", ill_pst, ill_i, ill_nst, decode_q(ill_pst));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
